// File: rtl/fxp_mult_seq.sv
// Sequential sign-magnitude fixed-point multiplier: one multiplier bit per cycle,
// shift-add into a 2N-2 bit accumulator, truncate to Q format and saturate on overflow.
module fxp_mult_seq #(
    parameter int N = 16,
    parameter int Q = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         overflow
);

    localparam int M  = N - 1;
    localparam int AW = 2 * N - 2;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [M-1:0]    mplier;
    logic [AW-1:0]   mcand_sh;
    logic [AW-1:0]   acc;
    logic            sign;
    logic [CW-1:0]   cnt;

    logic [AW-1:0]   acc_next;
    logic            ovf_next;
    logic [M-1:0]    mag_next;

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        acc_next = mplier[0] ? acc + mcand_sh : acc;
        ovf_next = |acc_next[AW-1:Q+M];
        mag_next = ovf_next ? {M{1'b1}} : acc_next[Q+M-1:Q];
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand registers are left unreset; they are always reloaded on acceptance.
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            c         <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand_sh <= {{M{1'b0}}, a[M-1:0]};
                        mplier   <= b[M-1:0];
                        sign     <= a[N-1] ^ b[N-1];
                        acc      <= '0;
                        cnt      <= CW'(M);
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // Multiplicand shifts left as the multiplier shifts right: bit i adds a << i.
                    acc      <= acc_next;
                    mcand_sh <= mcand_sh << 1;
                    mplier   <= mplier >> 1;
                    cnt      <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        c         <= {sign & (|mag_next), mag_next};
                        overflow  <= ovf_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_mult_seq.sv
// Directed bench for fxp_mult_seq (N=16, Q=12): vector table plus backpressure,
// mid-operation reset and back-to-back sequences.
module tb_fxp_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] c;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic        ovf;
    } vec_t;

    vec_t vecs[13];

    fxp_mult_seq #(.N(16), .Q(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Waits (bounded) for out_valid at negedges; returns the number of edges waited.
    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input string nm, input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] exp_c, input logic exp_ovf);
        int k;
        @(negedge clk);
        a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
        check({nm, ":in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = ~va; b = ~vb;
        wait_valid(k);
        check({nm, ":latency"}, 32'(k), 32'd15);
        check({nm, ":c"}, 32'(c), 32'(exp_c));
        check({nm, ":overflow"}, 32'(overflow), 32'(exp_ovf));
        @(posedge clk);
        @(negedge clk);
        check({nm, ":idle_out_valid"}, 32'(out_valid), 32'd0);
        check({nm, ":idle_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int k;
        logic [15:0] held_c;
        logic        held_ovf;

        vecs[0]  = '{"basic",      16'h1800, 16'hA000, 16'hB000, 1'b0};
        vecs[1]  = '{"sat_pos",    16'h4000, 16'h4000, 16'h7FFF, 1'b1};
        vecs[2]  = '{"sat_neg",    16'h4000, 16'hC000, 16'hFFFF, 1'b1};
        vecs[3]  = '{"zero_sign",  16'h0000, 16'h9000, 16'h0000, 1'b0};
        vecs[4]  = '{"trunc_zero", 16'h8001, 16'h0001, 16'h0000, 1'b0};
        vecs[5]  = '{"one",        16'h1000, 16'h1000, 16'h1000, 1'b0};
        vecs[6]  = '{"neg_one",    16'h9000, 16'h1800, 16'h9800, 1'b0};
        vecs[7]  = '{"halves",     16'h8800, 16'h8800, 16'h0400, 1'b0};
        vecs[8]  = '{"lsb",        16'h0001, 16'h1000, 16'h0001, 1'b0};
        vecs[9]  = '{"edge_max",   16'h2000, 16'h3FFF, 16'h7FFE, 1'b0};
        vecs[10] = '{"edge_ovf",   16'h2000, 16'h4000, 16'h7FFF, 1'b1};
        vecs[11] = '{"max_unit",   16'h7FFF, 16'h1000, 16'h7FFF, 1'b0};
        vecs[12] = '{"trunc_half", 16'h0003, 16'h0800, 16'h0001, 1'b0};

        // Reset with in_valid high: reset must win and nothing is accepted.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; a = 16'h1000; b = 16'h1000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("rst:in_ready", 32'(in_ready), 32'd1);
        check("rst:out_valid", 32'(out_valid), 32'd0);
        check("rst:c", 32'(c), 32'd0);
        check("rst:overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst:still_idle", 32'(in_ready), 32'd1);

        for (int i = 0; i < 13; i++)
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].ovf);

        // Backpressure: hold out_ready low, pulse in_valid with other operands.
        @(negedge clk);
        a = 16'h1800; b = 16'hA000; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(k);
        check("bp:latency", 32'(k), 32'd15);
        check("bp:c", 32'(c), 32'hB000);
        held_c = c; held_ovf = overflow;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = 16'h4000; b = 16'h4000;
            @(posedge clk);
            @(negedge clk);
            check("bp:hold_c", 32'(c), 32'(held_c));
            check("bp:hold_ovf", 32'(overflow), 32'(held_ovf));
            check("bp:hold_valid", 32'(out_valid), 32'd1);
            check("bp:in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp:release_valid", 32'(out_valid), 32'd0);
        check("bp:release_ready", 32'(in_ready), 32'd1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("bp:no_ghost_op", 32'(out_valid), 32'd0);
        check("bp:c_held_idle", 32'(c), 32'hB000);

        // Reset at BUSY cycle 7: the aborted result must never surface.
        a = 16'h7FFF; b = 16'h7FFF; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("mid:busy", 32'(in_ready), 32'd0);
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("mid:in_ready", 32'(in_ready), 32'd1);
        check("mid:out_valid", 32'(out_valid), 32'd0);
        check("mid:c", 32'(c), 32'd0);
        check("mid:overflow", 32'(overflow), 32'd0);
        wait_valid(k);
        check("mid:aborted_hidden", 32'(out_valid), 32'd0);
        run_op("mid_after", 16'h1000, 16'h1000, 16'h1000, 1'b0);

        // Back-to-back with in_valid held high.
        @(negedge clk);
        a = 16'h1800; b = 16'hA000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_valid(k);
        check("b2b:first_latency", 32'(k), 32'd15);
        check("b2b:first_c", 32'(c), 32'hB000);
        a = 16'h8800; b = 16'h8800;
        @(posedge clk);
        @(negedge clk);
        check("b2b:idle_gap_ready", 32'(in_ready), 32'd1);
        check("b2b:idle_gap_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b:second_accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_valid(k);
        check("b2b:second_latency", 32'(k), 32'd15);
        check("b2b:second_c", 32'(c), 32'h0400);
        check("b2b:second_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
